modulador_sched: RTL
====================

Name: modulador_sched

Overview:
Byte/frame scheduler that sequences the sinusoidal bit modulator.
- Buffers payload bytes from an upstream producer in a small FIFO.
- Prepends a fixed preamble and presents each byte on dado with bit and sample indices.
- Inserts a one-bit-time guard gap between frames.
- The modulator consumes dado[bit_sel] and sample_idx directly; this block owns all byte and bit timing.

Parameters:
SAMPLES_PER_BIT, 32, clocks per modulated bit; power of 2, ≥4
N_PREAMBLE, 2, preamble bytes per frame; 0 allowed
PREAMBLE_BYTE, 8'h55, preamble value
FIFO_DEPTH, 4, payload FIFO entries; power of 2, ≥2

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer has a byte
in_data  in  8  payload byte
in_last  in  1  byte is the last of the frame
in_ready  out  1  FIFO can accept; combinational !full
dado  out  8  byte currently being modulated
bit_sel  out  3  bit index of dado being modulated, 0..7, LSB first
sample_idx  out  log2(SAMPLES_PER_BIT)  sample phase within the current bit
tx_en  out  1  modulator active
byte_done  out  1  one-clock pulse after each byte's final sample
frame_done  out  1  one-clock pulse at the end of a frame, including aborts
underrun  out  1  one-clock pulse when a frame is aborted for lack of data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE; FIFO empty; dado, bit_sel, sample_idx, tx_en, byte_done, frame_done, underrun and busy all 0. in_ready=1 once reset deasserts. Reset mid-frame aborts immediately with no pulses and discards FIFO contents.
- FIFO:
  - 9-bit entries {last, data}.
  - Push when in_valid && in_ready. Pop when a payload byte is loaded.
  - When full, a pop and a push offered in the same cycle: the push is refused (in_ready=0 that cycle) and the pop proceeds.
  - Pointers wrap modulo FIFO_DEPTH; count is kept to distinguish full from empty.
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE:
  - If FIFO is non-empty, next clock goes to PREAMBLE with dado=PREAMBLE_BYTE, pre_cnt=0.
  - If N_PREAMBLE=0, go straight to PAYLOAD and pop the first byte.
  - tx_en=1 from that clock; bit_sel=0; sample_idx=0.
- Counters (PREAMBLE and PAYLOAD):
  - sample_idx increments every clock and wraps at SAMPLES_PER_BIT-1.
  - On wrap, bit_sel increments.
  - On (bit_sel==7 && sample_idx==max), the byte ends: byte_done pulses on the next clock, coincident with the next byte's sample 0.
  - Byte period = 8*SAMPLES_PER_BIT clocks, with no dead cycle between bytes.
- PREAMBLE end of byte:
  - pre_cnt increments.
  - If pre_cnt==N_PREAMBLE-1, pop the FIFO head into dado and go to PAYLOAD.
  - FIFO is non-empty here by construction, since entries are only removed by this block.
- PAYLOAD end of byte:
  - If the current byte had last=1: go to GAP; frame_done pulses.
  - Else if FIFO non-empty: pop into dado and stay in PAYLOAD.
  - Else (underrun): go to GAP; underrun and frame_done pulse in the same clock.
- GAP:
  - tx_en=0, dado=0, counters reset.
  - Lasts exactly SAMPLES_PER_BIT clocks, then returns to IDLE.
  - A new frame therefore starts at the earliest SAMPLES_PER_BIT+1 clocks after frame_done.
- dado is stable for an entire byte period and changes only at a byte boundary.
- Frame length for n payload bytes: (N_PREAMBLE+n)*8*SAMPLES_PER_BIT clocks of tx_en=1.

Optional Feature:
MODULADOR_SCHED_CKSUM_EN
- Defined:
  - An 8-bit XOR accumulator clears at frame start and XORs each popped payload byte.
  - After a last=1 byte, one extra byte equal to the accumulator is transmitted in PAYLOAD. It produces its own byte_done.
  - frame_done follows the checksum byte.
  - An underrun abort sends no checksum.
- Undefined: no accumulator and no extra byte.

Test Plan:
- Default parameters; push 8'hA5 with last=1 → tx_en high 768 clocks; dado sequence 55,55,A5; 3 byte_done pulses; frame_done at clock 768; then tx_en=0 for 32 clocks.
- Push 10,20,30 (last on 30) back-to-back → 5 contiguous bytes 55,55,10,20,30; no gap between them; sample_idx wraps 31→0 every 32 clocks.
- Push 11 (last=0) only → after 11 completes, underrun and frame_done pulse together; tx_en drops; FIFO empty.
- Hold in_valid with 6 bytes during a frame, FIFO_DEPTH=4 → in_ready=0 after 4 accepted; resumes one slot per pop; no byte lost or duplicated.
- Assert rst at bit_sel=3 of a payload byte → all outputs 0 asynchronously; no pulses; FIFO empty; after release, next push starts a new preamble.
- With MODULADOR_SCHED_CKSUM_EN: frame 0F,F0 (last) → bytes 55,55,0F,F0,FF; 5 byte_done pulses, then frame_done.

Source files
------------

// File: rtl/modulador_sched_if.sv
// Producer-side byte stream into the modulator scheduler.
// The producer drives the master modport; the scheduler takes the slave modport.
interface modulador_sched_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/modulador_sched.sv
// Byte/frame scheduler for the sinusoidal bit modulator.
// Buffers payload bytes, prepends the preamble, walks bit_sel/sample_idx
// through every byte and inserts a one-bit-time guard gap between frames.
// Optional: define MODULADOR_SCHED_CKSUM_EN to append an XOR checksum byte
// after the last payload byte of every completed frame.
module modulador_sched #(
   parameter int unsigned SAMPLES_PER_BIT = 32,
   parameter int unsigned N_PREAMBLE      = 2,
   parameter logic [7:0]  PREAMBLE_BYTE   = 8'h55,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   modulador_sched_if.slave                   up,
   output logic [7:0]                         dado,
   output logic [2:0]                         bit_sel,
   output logic [$clog2(SAMPLES_PER_BIT)-1:0] sample_idx,
   output logic                               tx_en,
   output logic                               byte_done,
   output logic                               frame_done,
   output logic                               underrun,
   output logic                               busy
);

   localparam int unsigned SW  = $clog2(SAMPLES_PER_BIT);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned PCW = (N_PREAMBLE > 1) ? $clog2(N_PREAMBLE) : 1;
   localparam logic [SW-1:0]  SAMP_MAX  = SW'(SAMPLES_PER_BIT - 1);
   localparam logic [PCW-1:0] PRE_LAST  = PCW'((N_PREAMBLE > 0) ? N_PREAMBLE - 1 : 0);
   localparam logic [PW:0]    FIFO_FULL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

   // Payload FIFO: {last, data} entries, count distinguishes full from empty.
   logic [8:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          fifo_empty, fifo_full, push, pop;
   logic [8:0]    head;

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == FIFO_FULL);
   assign up.in_ready = !fifo_full;  // a pop in the same cycle does not open a slot
   assign push        = up.in_valid && !fifo_full;
   assign head        = mem[rd_ptr];

   // FIFO pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // FIFO storage write.
   // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {up.in_last, up.in_data};
   end

   // Sequencer state and its next values.
   state_t         state, state_d;
   logic [7:0]     dado_d;
   logic [2:0]     bit_sel_d;
   logic [SW-1:0]  sample_d, gap_cnt, gap_cnt_d;
   logic [PCW-1:0] pre_cnt, pre_cnt_d;
   logic           cur_last, cur_last_d, tx_en_d;
   logic           byte_done_d, frame_done_d, underrun_d;
   logic           load, finish;
`ifdef MODULADOR_SCHED_CKSUM_EN
   logic [7:0]     cks, cks_d;            // running XOR of popped payload bytes
   logic           cks_sent, cks_sent_d;  // byte on dado is the checksum
`endif

   assign busy = (state != S_IDLE);

   // Next-state, counter and pulse decode for the frame sequencer.
   // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
   always_comb begin
      state_d      = state;
      dado_d       = dado;
      bit_sel_d    = bit_sel;
      sample_d     = sample_idx;
      pre_cnt_d    = pre_cnt;
      gap_cnt_d    = gap_cnt;
      cur_last_d   = cur_last;
      tx_en_d      = tx_en;
      byte_done_d  = 1'b0;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
      pop          = 1'b0;
      load         = 1'b0;
      finish       = 1'b0;
`ifdef MODULADOR_SCHED_CKSUM_EN
      cks_d        = cks;
      cks_sent_d   = cks_sent;
`endif
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               tx_en_d   = 1'b1;
               bit_sel_d = '0;
               sample_d  = '0;
               pre_cnt_d = '0;
`ifdef MODULADOR_SCHED_CKSUM_EN
               cks_d      = '0;
               cks_sent_d = 1'b0;
`endif
               if (N_PREAMBLE == 0) begin
                  state_d = S_PAYLOAD;
                  load    = 1'b1;
               end else begin
                  state_d = S_PREAMBLE;
                  dado_d  = PREAMBLE_BYTE;
               end
            end
         end
         S_PREAMBLE, S_PAYLOAD: begin
            sample_d = sample_idx + 1'b1;
            if (sample_idx == SAMP_MAX) bit_sel_d = bit_sel + 1'b1;
            if (bit_sel == 3'd7 && sample_idx == SAMP_MAX) begin
               byte_done_d = 1'b1;
               if (state == S_PREAMBLE) begin
                  pre_cnt_d = pre_cnt + 1'b1;
                  // Entries leave only through this block, so the head is valid here.
                  if (pre_cnt == PRE_LAST) begin
                     state_d = S_PAYLOAD;
                     load    = 1'b1;
                  end
               end
`ifdef MODULADOR_SCHED_CKSUM_EN
               else if (cks_sent) finish = 1'b1;
               else if (cur_last) begin
                  dado_d     = cks;
                  cks_sent_d = 1'b1;
               end
`else
               else if (cur_last) finish = 1'b1;
`endif
               else if (!fifo_empty) load = 1'b1;
               else begin
                  finish     = 1'b1;
                  underrun_d = 1'b1;
               end
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt + 1'b1;
            if (gap_cnt == SAMP_MAX) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         pop        = 1'b1;
         dado_d     = head[7:0];
         cur_last_d = head[8];
`ifdef MODULADOR_SCHED_CKSUM_EN
         cks_d      = cks_d ^ head[7:0];
`endif
      end
      if (finish) begin
         state_d      = S_GAP;
         tx_en_d      = 1'b0;
         dado_d       = '0;
         bit_sel_d    = '0;
         sample_d     = '0;
         gap_cnt_d    = '0;
         frame_done_d = 1'b1;
      end
   end

   // Sequencer registers; reset aborts any frame without pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         dado       <= '0;
         bit_sel    <= '0;
         sample_idx <= '0;
         pre_cnt    <= '0;
         gap_cnt    <= '0;
         cur_last   <= 1'b0;
         tx_en      <= 1'b0;
         byte_done  <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
`ifdef MODULADOR_SCHED_CKSUM_EN
         cks        <= '0;
         cks_sent   <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         dado       <= dado_d;
         bit_sel    <= bit_sel_d;
         sample_idx <= sample_d;
         pre_cnt    <= pre_cnt_d;
         gap_cnt    <= gap_cnt_d;
         cur_last   <= cur_last_d;
         tx_en      <= tx_en_d;
         byte_done  <= byte_done_d;
         frame_done <= frame_done_d;
         underrun   <= underrun_d;
`ifdef MODULADOR_SCHED_CKSUM_EN
         cks        <= cks_d;
         cks_sent   <= cks_sent_d;
`endif
      end
   end

endmodule
